// File: rtl/banco_pkg.sv
// Shared constants and FSM state type for the
// four-bank memory controller.
package banco_pkg;

  localparam int ADDR_W = 13;
  localparam int BANK_W = 2;
  localparam int WORD_W = 11;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP
  } state_t;

endpackage

// File: rtl/controlador_banco.sv
// Single-request bank controller: one access per request, read capture and response hold.
// Optional write acknowledge beat enabled with macro CTRL_WRITE_ACK_EN.
module controlador_banco
  import banco_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_write,
  output logic [BANK_W-1:0]         Sel_Mem,
  output logic                      Eneable,
  output logic [WORD_W-1:0]         Address,
  output logic [DATA_W-1:0]         Data,
  output logic                      WriteEneable,
  input  logic [DATA_W-1:0]         LineData
);

  state_t              r_state;
  state_t              w_next;
  state_t              w_wr_next;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_accept;

`ifdef CTRL_WRITE_ACK_EN
  logic                r_rsp_write;
  assign w_wr_next = RESP;
  assign rsp_write = RST ? 1'b0 : r_rsp_write;
`else
  assign w_wr_next = IDLE;
  assign rsp_write = 1'b0;
`endif

  assign w_accept = req_valid & req_ready;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    Eneable      = 1'b0;
    WriteEneable = 1'b1;
    rsp_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = ACCESS;
      end
      ACCESS: begin
        Eneable      = 1'b1;
        WriteEneable = ~r_write;
        w_next       = r_write ? w_wr_next : CAPTURE;
      end
      CAPTURE: w_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // reset forces quiet bank and handshake outputs
    if (RST) begin
      req_ready    = 1'b0;
      Eneable      = 1'b0;
      WriteEneable = 1'b1;
      rsp_valid    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef CTRL_WRITE_ACK_EN
      r_rsp_write <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_addr  <= req_addr;
        r_write <= req_write;
        r_wdata <= req_wdata;
      end
      if (r_state == CAPTURE) begin
        r_rdata <= LineData;
`ifdef CTRL_WRITE_ACK_EN
        r_rsp_write <= 1'b0;
`endif
      end
`ifdef CTRL_WRITE_ACK_EN
      if (r_state == ACCESS && r_write) begin
        r_rdata     <= '0;
        r_rsp_write <= 1'b1;
      end
`endif
    end
  end

  assign Sel_Mem   = RST ? '0 : r_addr[ADDR_W-1:WORD_W];
  assign Address   = RST ? '0 : r_addr[WORD_W-1:0];
  assign Data      = RST ? '0 : r_wdata;
  assign rsp_rdata = RST ? '0 : r_rdata;

endmodule

// File: tb/tb_controlador_banco.sv
// Bench for controlador_banco: bank memory stub, transaction-level
// reference model compared every cycle, and directed literal checks.
module tb_controlador_banco;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [12:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_write;
  logic [1:0]  Sel_Mem;
  logic        Eneable;
  logic [10:0] Address;
  logic [63:0] Data;
  logic        WriteEneable;
  logic [63:0] LineData;

`ifdef CTRL_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;

  controlador_banco dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_write(rsp_write),
    .Sel_Mem(Sel_Mem), .Eneable(Eneable),
    .Address(Address), .Data(Data),
    .WriteEneable(WriteEneable), .LineData(LineData)
  );

  always #5 CLK = ~CLK;

  // bank array stub: read data appears the cycle after the access
  logic [63:0] bmem [0:8191];
  always @(posedge CLK) begin
    if (Eneable) begin
      if (!WriteEneable) bmem[{Sel_Mem, Address}] <= Data;
      else LineData <= bmem[{Sel_Mem, Address}];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // transaction-level reference model
  logic [63:0] gmem [0:8191];
  bit          m_busy = 1'b0;
  int          m_k = 0;
  bit          m_w;
  logic [12:0] m_a;
  logic [63:0] m_d;
  logic [63:0] m_exp;

  always @(posedge CLK) begin
    if (RST) m_busy = 1'b0;
    else if (m_busy) begin
      if (m_w && !ACK && m_k >= 1) m_busy = 1'b0;
      else if (m_k >= (m_w ? 2 : 3) && rsp_ready) m_busy = 1'b0;
      else m_k++;
    end else if (req_valid) begin
      m_busy = 1'b1;
      m_k    = 1;
      m_w    = req_write;
      m_a    = req_addr;
      m_d    = req_wdata;
      m_exp  = req_write ? 64'd0 : gmem[req_addr];
      if (req_write) gmem[req_addr] = req_wdata;
    end
  end

  always @(negedge CLK) begin
    if (run) begin
      if (RST) begin
        chk("m_rst_ready", 64'(req_ready), 64'd0);
        chk("m_rst_rvalid", 64'(rsp_valid), 64'd0);
        chk("m_rst_rdata", rsp_rdata, 64'd0);
        chk("m_rst_rwrite", 64'(rsp_write), 64'd0);
        chk("m_rst_en", 64'(Eneable), 64'd0);
        chk("m_rst_we", 64'(WriteEneable), 64'd1);
        chk("m_rst_sel", 64'(Sel_Mem), 64'd0);
        chk("m_rst_addr", 64'(Address), 64'd0);
        chk("m_rst_data", Data, 64'd0);
      end else if (!m_busy) begin
        chk("m_idle_ready", 64'(req_ready), 64'd1);
        chk("m_idle_rvalid", 64'(rsp_valid), 64'd0);
        chk("m_idle_en", 64'(Eneable), 64'd0);
        chk("m_idle_we", 64'(WriteEneable), 64'd1);
      end else begin
        chk("m_busy_ready", 64'(req_ready), 64'd0);
        chk("m_en", 64'(Eneable), 64'(m_k == 1));
        chk("m_we", 64'(WriteEneable), 64'(!(m_k == 1 && m_w)));
        chk("m_rvalid", 64'(rsp_valid),
            64'(m_k >= (m_w ? 2 : 3)));
        if (m_k == 1) begin
          chk("m_sel", 64'(Sel_Mem), 64'(m_a[12:11]));
          chk("m_addr", 64'(Address), 64'(m_a[10:0]));
          chk("m_data", Data, m_d);
        end
        if (!m_w && m_k == 2)
          chk("m_sel_hold", 64'(Sel_Mem), 64'(m_a[12:11]));
        if (m_k >= (m_w ? 2 : 3)) begin
          chk("m_rdata", rsp_rdata, m_exp);
          chk("m_rwrite", 64'(rsp_write), 64'(m_w));
        end
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      failures++;
      $display("FAIL idle_timeout act=busy exp=idle t=%0t", $time);
    end
  endtask

  task automatic issue(input logic w, input logic [12:0] a,
                       input logic [63:0] d);
    wait_idle();
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8192; i++) begin
      bmem[i] = 64'd0;
      gmem[i] = 64'd0;
    end
    LineData  = 64'd0;
    RST       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 13'd0;
    req_wdata = 64'd0;
    rsp_ready = 1'b1;
    run       = 1'b1;
    repeat (3) tick();
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_we", 64'(WriteEneable), 64'd1);
    RST = 1'b0;
    #1;
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    // write then read back
    issue(1'b1, 13'h0805, 64'hDEADBEEF_01234567);
    chk("wr_en", 64'(Eneable), 64'd1);
    chk("wr_we", 64'(WriteEneable), 64'd0);
    chk("wr_sel", 64'(Sel_Mem), 64'd1);
    chk("wr_addr", 64'(Address), 64'd5);
    wait_idle();
    issue(1'b0, 13'h0805, 64'd0);
    chk("rd_we", 64'(WriteEneable), 64'd1);
    tick();
    chk("rd_t2_rvalid", 64'(rsp_valid), 64'd0);
    tick();
    chk("rd_t3_rvalid", 64'(rsp_valid), 64'd1);
    chk("rd_t3_rdata", rsp_rdata, 64'hDEADBEEF_01234567);
    tick();
    chk("rd_t4_ready", 64'(req_ready), 64'd1);

    // bank isolation
    issue(1'b1, 13'h0000, 64'h1111_1111_1111_1111);
    wait_idle();
    issue(1'b1, 13'h1800, 64'h2222_2222_2222_2222);
    wait_idle();
    issue(1'b0, 13'h0000, 64'd0);
    chk("iso0_sel", 64'(Sel_Mem), 64'd0);
    tick();
    tick();
    chk("iso0_rdata", rsp_rdata, 64'h1111_1111_1111_1111);
    tick();
    issue(1'b0, 13'h1800, 64'd0);
    chk("iso3_sel", 64'(Sel_Mem), 64'd3);
    tick();
    tick();
    chk("iso3_rdata", rsp_rdata, 64'h2222_2222_2222_2222);
    tick();

    // backpressure, with an ignored request while busy
    rsp_ready = 1'b0;
    issue(1'b0, 13'h0805, 64'd0);
    tick();
    tick();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 13'h0805;
    req_wdata = 64'h0BAD_0BAD_0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_rvalid", 64'(rsp_valid), 64'd1);
      chk("bp_rdata", rsp_rdata, 64'hDEADBEEF_01234567);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_ready", 64'(req_ready), 64'd1);

    // boundary address
    issue(1'b1, 13'h1FFF, 64'hA5A5_5A5A_C3C3_3C3C);
    chk("bnd_w_addr", 64'(Address), 64'h7FF);
    chk("bnd_w_sel", 64'(Sel_Mem), 64'd3);
    wait_idle();
    issue(1'b0, 13'h1FFF, 64'd0);
    chk("bnd_r_addr", 64'(Address), 64'h7FF);
    chk("bnd_r_sel", 64'(Sel_Mem), 64'd3);
    tick();
    tick();
    chk("bnd_rdata", rsp_rdata, 64'hA5A5_5A5A_C3C3_3C3C);
    tick();

    // reset during CAPTURE
    issue(1'b0, 13'h0805, 64'd0);
    tick();
    RST = 1'b1;
    #1;
    chk("rstc_en", 64'(Eneable), 64'd0);
    chk("rstc_rvalid", 64'(rsp_valid), 64'd0);
    tick();
    RST = 1'b0;
    #1;
    chk("rstc_ready", 64'(req_ready), 64'd1);
    chk("rstc_rvalid2", 64'(rsp_valid), 64'd0);
    tick();
    chk("rstc_rvalid3", 64'(rsp_valid), 64'd0);

    // write acknowledge
    issue(1'b1, 13'h0010, 64'h77);
    tick();
`ifdef CTRL_WRITE_ACK_EN
    chk("ack_rvalid", 64'(rsp_valid), 64'd1);
    chk("ack_rwrite", 64'(rsp_write), 64'd1);
    chk("ack_rdata", rsp_rdata, 64'd0);
    tick();
    chk("ack_done_ready", 64'(req_ready), 64'd1);
`else
    chk("noack_rvalid", 64'(rsp_valid), 64'd0);
    chk("noack_ready", 64'(req_ready), 64'd1);
`endif

    // ignored request left the data untouched
    issue(1'b0, 13'h0805, 64'd0);
    tick();
    tick();
    chk("ign_rdata", rsp_rdata, 64'hDEADBEEF_01234567);
    tick();

    repeat (3) tick();
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
